// File: rtl/led_pkg.sv
// Shared definitions for the LED colour engine: mode encodings, flash phases,
// the 16-entry front-panel palette and the palette-byte widening helper.
package led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_SOLID   = 2'd1;
  localparam logic [1:0] MODE_FLASH   = 2'd2;
  localparam logic [1:0] MODE_RAINBOW = 2'd3;

  typedef enum logic {
    FL_LIT  = 1'b0,
    FL_DARK = 1'b1
  } flash_st_e;

  // {R,G,B} as 8-bit values; codes 10-15 are black.
  localparam logic [23:0] PALETTE [16] = '{
    24'hFFFFFF, 24'hFFFF00, 24'hFF6400, 24'hFF0000,
    24'hFF00FF, 24'h6400FF, 24'h0000FF, 24'h00FFFF,
    24'h00FF00, 24'h006400, 24'h000000, 24'h000000,
    24'h000000, 24'h000000, 24'h000000, 24'h000000
  };

  // Widen a palette byte to w bits; full-scale 255 must land on all-ones.
  function automatic logic [31:0] scale_byte(input logic [7:0] b, input int unsigned w);
    if (b == 8'hFF) return 32'hFFFF_FFFF >> (32 - w);
    return {24'd0, b} << (w - 8);
  endfunction

endpackage

// File: rtl/led_color_engine_if.sv
// Front-panel / PWM-driver bundle: the panel (master) drives mode, brightness
// and colour code; the engine (slave) returns the colour, tick and flash phase.
interface led_color_engine_if #(
  parameter int COLOR_W = 8
);
  logic [1:0]           mode;
  logic [3:0]           brightness;
  logic [3:0]           color_code;
  logic [3*COLOR_W-1:0] color_out;
  logic                 tick;
  logic                 flash_lit;

  modport master (
    output mode, brightness, color_code,
    input  color_out, tick, flash_lit
  );

  modport slave (
    input  mode, brightness, color_code,
    output color_out, tick, flash_lit
  );
endinterface

// File: rtl/led_brightness_scaler.sv
// One colour channel dimmed by a 16-level global brightness: a fixed
// per-level offset is subtracted from the channel, clamping at zero.
module led_brightness_scaler #(
  parameter int COLOR_W = 8
) (
  input  logic [COLOR_W-1:0] chan_i,
  input  logic [3:0]         brightness_i,
  output logic [COLOR_W-1:0] chan_o
);

  localparam logic [COLOR_W-1:0] MAX  = '1;
  localparam logic [COLOR_W-1:0] STEP = MAX / COLOR_W'(15);

  function automatic logic [COLOR_W-1:0] sat_sub(input logic [COLOR_W-1:0] a,
                                                 input logic [COLOR_W+3:0] s);
    if (s > {4'd0, a}) return '0;
    return COLOR_W'({4'd0, a} - s);
  endfunction

  logic [COLOR_W+3:0] sub;

  assign sub    = {4'd0, STEP} * {{COLOR_W{1'b0}}, 4'd15 - brightness_i};
  assign chan_o = (brightness_i == 4'd0) ? '0 : sat_sub(chan_i, sub);

endmodule

// File: rtl/led_color_engine.sv
// LED colour engine: off/solid/flash/rainbow modes with brightness scaling,
// an animation-tick prescaler, a timed flash phase and a hue-wheel generator.
module led_color_engine
  import led_pkg::*;
#(
  parameter int COLOR_W   = 8,
  parameter int TICK_DIV  = 1000000,
  parameter int FLASH_ON  = 2,
  parameter int FLASH_OFF = 2,
  parameter int HUE_STEP  = 1
) (
  input logic              clk,
  input logic              rst_n,
  led_color_engine_if.slave bus
);

  localparam logic [COLOR_W-1:0] MAX      = '1;
  localparam int                 PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int                 FCNT_MAX = (FLASH_ON > FLASH_OFF) ? FLASH_ON : FLASH_OFF;
  localparam int                 FCNT_W   = (FCNT_MAX > 1) ? $clog2(FCNT_MAX) : 1;
  localparam int                 HUE_W    = COLOR_W + 3;
  localparam logic [HUE_W-1:0]   HUE_MOD  = HUE_W'(6) << COLOR_W;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [1:0]           mode_q;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 tick_q, tick_d;
  flash_st_e            fst_q, fst_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic [HUE_W-1:0]     hue_q, hue_d, hue_sum;
  logic [3*COLOR_W-1:0] color_q, color_d;

  logic mode_chg, tick_evt;

  assign mode_chg = (bus.mode != mode_q);
  // A tick event and the state it advances land on the same edge as the tick pulse.
  assign tick_evt = !mode_chg && (presc_q == PRESC_LAST);
  assign hue_sum  = hue_q + HUE_W'(HUE_STEP);

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    fst_d   = fst_q;
    fcnt_d  = fcnt_q;
    hue_d   = hue_q;
    if (mode_chg) begin
      presc_d = '0;
      fst_d   = FL_LIT;
      fcnt_d  = '0;
      hue_d   = '0;
    end else begin
      presc_d = tick_evt ? '0 : presc_q + PRESC_W'(1);
      tick_d  = tick_evt;
      if (tick_evt && bus.mode == MODE_FLASH) begin
        if (fst_q == FL_LIT) begin
          if (fcnt_q == FCNT_W'(FLASH_ON - 1)) begin
            fst_d  = FL_DARK;
            fcnt_d = '0;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end else begin
          if (fcnt_q == FCNT_W'(FLASH_OFF - 1)) begin
            fst_d  = FL_LIT;
            fcnt_d = '0;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end
      if (tick_evt && bus.mode == MODE_RAINBOW)
        hue_d = (hue_sum >= HUE_MOD) ? hue_sum - HUE_MOD : hue_sum;
    end
  end

  logic [2:0]           seg;
  logic [COLOR_W-1:0]   f;
  logic [3*COLOR_W-1:0] wheel, pal, raw, scaled;
  logic [23:0]          pal_word;

  assign seg = hue_q[HUE_W-1:COLOR_W];
  assign f   = hue_q[COLOR_W-1:0];

  always_comb begin
    wheel = '0;
    case (seg)
      3'd0:    wheel = {MAX, f, {COLOR_W{1'b0}}};
      3'd1:    wheel = {MAX - f, MAX, {COLOR_W{1'b0}}};
      3'd2:    wheel = {{COLOR_W{1'b0}}, MAX, f};
      3'd3:    wheel = {{COLOR_W{1'b0}}, MAX - f, MAX};
      3'd4:    wheel = {f, {COLOR_W{1'b0}}, MAX};
      3'd5:    wheel = {MAX, {COLOR_W{1'b0}}, MAX - f};
      default: wheel = '0;
    endcase
  end

  assign pal_word = PALETTE[bus.color_code];
  assign pal = {COLOR_W'(scale_byte(pal_word[23:16], COLOR_W)),
                COLOR_W'(scale_byte(pal_word[15:8],  COLOR_W)),
                COLOR_W'(scale_byte(pal_word[7:0],   COLOR_W))};
  assign raw = (bus.mode == MODE_RAINBOW) ? wheel : pal;

  led_brightness_scaler #(.COLOR_W(COLOR_W)) u_scale_r (
    .chan_i(raw[3*COLOR_W-1:2*COLOR_W]), .brightness_i(bus.brightness),
    .chan_o(scaled[3*COLOR_W-1:2*COLOR_W]));
  led_brightness_scaler #(.COLOR_W(COLOR_W)) u_scale_g (
    .chan_i(raw[2*COLOR_W-1:COLOR_W]), .brightness_i(bus.brightness),
    .chan_o(scaled[2*COLOR_W-1:COLOR_W]));
  led_brightness_scaler #(.COLOR_W(COLOR_W)) u_scale_b (
    .chan_i(raw[COLOR_W-1:0]), .brightness_i(bus.brightness),
    .chan_o(scaled[COLOR_W-1:0]));

  always_comb begin
    color_d = '0;
    case (bus.mode)
      MODE_SOLID:   color_d = scaled;
      MODE_FLASH:   color_d = (fst_q == FL_LIT) ? scaled : '0;
      MODE_RAINBOW: color_d = scaled;
      default:      color_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      presc_q <= '0;
      tick_q  <= 1'b0;
      fst_q   <= FL_LIT;
      fcnt_q  <= '0;
      hue_q   <= '0;
      color_q <= '0;
    end else begin
      mode_q  <= bus.mode;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      fst_q   <= fst_d;
      fcnt_q  <= fcnt_d;
      hue_q   <= hue_d;
      color_q <= color_d;
    end
  end

  assign bus.color_out = color_q;
  assign bus.tick      = tick_q;
  assign bus.flash_lit = (fst_q == FL_LIT);

endmodule

// File: tb/tb_led_color_engine.sv
// Bench for led_color_engine: directed scenarios plus random mode/colour
// traffic, every cycle compared against a tick-count based reference model.
module tb_led_color_engine;

  localparam int TD   = 4;
  localparam int ON   = 2;
  localparam int OFF  = 2;
  localparam int STEP = 64;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   j = 0;          // edges since last mode change (or reset)
  int   prev_mode = 0;

  led_color_engine_if #(.COLOR_W(8)) bus ();

  led_color_engine #(
    .COLOR_W(8), .TICK_DIV(TD), .FLASH_ON(ON), .FLASH_OFF(OFF), .HUE_STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [23:0] pal_tb [16];
  initial begin
    pal_tb = '{24'hFFFFFF, 24'hFFFF00, 24'hFF6400, 24'hFF0000, 24'hFF00FF,
               24'h6400FF, 24'h0000FF, 24'h00FFFF, 24'h00FF00, 24'h006400,
               24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
  end

  function automatic int dim(int c, int b);
    int sub;
    sub = 17 * (15 - b);
    if (b == 0 || sub > c) return 0;
    return c - sub;
  endfunction

  function automatic logic [23:0] scale(logic [23:0] c, int b);
    return {8'(dim(int'(c[23:16]), b)), 8'(dim(int'(c[15:8]), b)), 8'(dim(int'(c[7:0]), b))};
  endfunction

  function automatic logic [23:0] wheel(int hue);
    int s, f;
    s = hue / 256;
    f = hue % 256;
    case (s)
      0: return {8'd255, 8'(f), 8'd0};
      1: return {8'(255 - f), 8'd255, 8'd0};
      2: return {8'd0, 8'd255, 8'(f)};
      3: return {8'd0, 8'(255 - f), 8'd255};
      4: return {8'(f), 8'd0, 8'd255};
      default: return {8'd255, 8'd0, 8'(255 - f)};
    endcase
  endfunction

  // Output after edge jj reflects the state left by the previous edge.
  function automatic logic [23:0] exp_color(int md, int b, int code, int jj);
    int tc;
    tc = (jj == 0) ? 0 : (jj - 1) / TD;
    case (md)
      1: return scale(pal_tb[code], b);
      2: return ((tc % (ON + OFF)) < ON) ? scale(pal_tb[code], b) : 24'h0;
      3: return scale(wheel((tc * STEP) % 1536), b);
      default: return 24'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int m, input int b, input int c);
    bus.mode       = 2'(m);
    bus.brightness = 4'(b);
    bus.color_code = 4'(c);
  endtask

  task automatic cyc();
    int exp_tick, exp_lit;
    @(posedge clk);
    if (int'(bus.mode) != prev_mode) j = 0;
    else j++;
    prev_mode = int'(bus.mode);
    #1;
    exp_tick = (j > 0 && j % TD == 0) ? 1 : 0;
    exp_lit  = (prev_mode == 2) ? ((((j / TD) % (ON + OFF)) < ON) ? 1 : 0) : 1;
    check("color", 32'(bus.color_out),
          32'(exp_color(prev_mode, int'(bus.brightness), int'(bus.color_code), j)));
    check("tick", 32'(bus.tick), 32'(exp_tick));
    check("flash_lit", 32'(bus.flash_lit), 32'(exp_lit));
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0);
    #12;
    check("rst_color", 32'(bus.color_out), 32'h0);
    check("rst_tick", 32'(bus.tick), 32'h0);
    check("rst_lit", 32'(bus.flash_lit), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    j = 0;
    prev_mode = 0;
    cyc();

    // Solid colour and brightness scaling
    set_in(1, 15, 0); cyc(); check("solid_white", 32'(bus.color_out), 32'hFFFFFF);
    set_in(1, 10, 0); cyc(); check("solid_b10", 32'(bus.color_out), 32'hAAAAAA);
    set_in(1, 12, 5); cyc(); check("solid_purple", 32'(bus.color_out), 32'h3100CC);
    set_in(1, 0, 5);  cyc(); check("solid_b0", 32'(bus.color_out), 32'h000000);

    // Flash timing
    set_in(2, 15, 3); cyc(); check("flash_start", 32'(bus.color_out), 32'hFF0000);
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (j == 8) check("flash_first_dark", 32'(bus.flash_lit), 32'h0);
      if (j == 9) check("flash_dark_col", 32'(bus.color_out), 32'h000000);
      if (j == 17) check("flash_relit_col", 32'(bus.color_out), 32'hFF0000);
    end

    // Leave flash while dark, come back: phase and prescaler restart
    set_in(1, 15, 3);
    for (int k = 0; k < 3; k++) cyc();
    set_in(2, 15, 3); cyc(); check("reentry_lit", 32'(bus.flash_lit), 32'h1);
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (j == 7) check("reentry_still_lit", 32'(bus.flash_lit), 32'h1);
      if (j == 8) check("reentry_dark", 32'(bus.flash_lit), 32'h0);
    end

    // Rainbow progression and wrap
    set_in(3, 15, 7); cyc(); check("rb_start", 32'(bus.color_out), 32'hFF0000);
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (j == 5)  check("rb_tick1", 32'(bus.color_out), 32'hFF4000);
      if (j == 17) check("rb_tick4", 32'(bus.color_out), 32'hFFFF00);
      if (j == 97) check("rb_wrap", 32'(bus.color_out), 32'hFF0000);
    end

    // Rainbow at half brightness in segment 3
    set_in(0, 8, 0); cyc();
    set_in(3, 8, 0); cyc();
    for (int k = 0; k < 57; k++) cyc();
    check("rb_seg3_b8", 32'(bus.color_out), 32'h000888);

    // Asynchronous reset between edges, mid-animation
    set_in(3, 15, 0);
    for (int k = 0; k < 10; k++) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_color", 32'(bus.color_out), 32'h0);
    check("arst_lit", 32'(bus.flash_lit), 32'h1);
    check("arst_tick", 32'(bus.tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    j = 0;
    prev_mode = 0;
    cyc(); check("arst_hue0", 32'(bus.color_out), 32'hFF0000);
    for (int k = 0; k < 6; k++) cyc();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) bus.brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus.color_code = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
